// File: rtl/jk_bank_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : jk_bank_ctrl_pkg
// Purpose : Shared opcode encodings, controller state encoding and a small
//           opcode-classification helper for the JK bank controller.
// Revision: 1.0 - initial release
// ============================================================================
package jk_bank_ctrl_pkg;

  // Command opcodes carried on cmd_op_i
  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_LOAD       = 3'd1;
  localparam logic [2:0] OP_CLEAR      = 3'd2;
  localparam logic [2:0] OP_SET        = 3'd3;
  localparam logic [2:0] OP_TOGGLE     = 3'd4;
  localparam logic [2:0] OP_COUNT_UP   = 3'd5;
  localparam logic [2:0] OP_COUNT_DOWN = 3'd6;
  localparam logic [2:0] OP_ILLEGAL    = 3'd7;

  // Controller states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // True for the multi-step counting opcodes
  function automatic logic is_count_op(input logic [2:0] op);
    return (op == OP_COUNT_UP) || (op == OP_COUNT_DOWN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_bank_ctrl_jk_cell.sv
`default_nettype none
// ============================================================================
// Module  : jk_cell
// Purpose : Single JK flip-flop with synchronous active-high reset.
//           J=K=0 hold, J=1/K=0 set, J=0/K=1 clear, J=K=1 toggle.
// Ports   : clk  - clock
//           rst  - synchronous active-high reset (q -> 0)
//           j_i  - J excitation
//           k_i  - K excitation
//           q_o  - flip-flop output
// Revision: 1.0 - initial release
// ============================================================================
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      case ({j_i, k_i})
        2'b00:   q_q <= q_q;
        2'b10:   q_q <= 1'b1;
        2'b01:   q_q <= 1'b0;
        default: q_q <= ~q_q;
      endcase
    end
  end

  assign q_o = q_q;

endmodule
`default_nettype wire

// File: rtl/jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : jk_bank_ctrl
// Purpose : Command sequencer for a bank of WIDTH JK flip-flops. Accepts one
//           command at a time over valid/ready and generates per-bit J/K
//           excitation to load, clear, set, toggle or count the bank N steps.
// Ports   : clk          - clock, all state on posedge
//           rst          - synchronous active-high reset
//           cmd_valid_i  - command present
//           cmd_ready_o  - command can be accepted (IDLE, not in reset)
//           cmd_op_i     - opcode
//           cmd_data_i   - LOAD value / TOGGLE mask
//           cmd_count_i  - step count for COUNT_UP / COUNT_DOWN
//           abort_i      - terminate a running count
//           q_o          - bank state (flip-flop outputs)
//           busy_o       - high while executing
//           done_o       - one-cycle pulse, command finished
//           wrap_o       - one-cycle pulse, count step wrapped
//           err_o        - one-cycle pulse with done for illegal opcode
// Revision: 1.0 - initial release
// ============================================================================
module jk_bank_ctrl
  import jk_bank_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic [CNT_W-1:0] cmd_count_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] q_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o,
  output logic             err_o
);

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   j_vec, k_vec;
  logic [WIDTH-1:0]   bank_q;
  logic [WIDTH-1:0]   up_en, dn_en;
  logic               all_ones, all_zero;

  // --------------------------------------------------------------------------
  // Counter excitation: a bit toggles on an up step when every lower bit is 1,
  // and on a down step when every lower bit is 0. Bit 0 always toggles.
  // --------------------------------------------------------------------------
  assign up_en[0] = 1'b1;
  assign dn_en[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_prefix
    assign up_en[i] = &bank_q[i-1:0];
    assign dn_en[i] = ~|bank_q[i-1:0];
  end

  // A step from these values is the one that wraps
  assign all_ones = &bank_q;
  assign all_zero = ~|bank_q;

  // --------------------------------------------------------------------------
  // Next-state, command latching and J/K excitation
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    j_vec   = '0;
    k_vec   = '0;

    case (state_q)
      ST_IDLE: begin
        // Reset forces the state register, so acceptance during rst is moot
        if (cmd_valid_i) begin
          state_d = ST_EXEC;
          op_d    = cmd_op_i;
          data_d  = cmd_data_i;
          cnt_d   = cmd_count_i;
        end
      end

      ST_EXEC: begin
        if (is_count_op(op_q)) begin
          if ((cnt_q == '0) || abort_i) begin
            // Nothing to do, or aborted: bank holds its last completed step
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            if (op_q == OP_COUNT_UP) begin
              j_vec  = up_en;
              k_vec  = up_en;
              wrap_d = all_ones;
            end else begin
              j_vec  = dn_en;
              k_vec  = dn_en;
              wrap_d = all_zero;
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          // Single-cycle commands; abort has no effect here
          case (op_q)
            OP_LOAD: begin
              j_vec = data_q;
              k_vec = ~data_q;
            end
            OP_CLEAR: begin
              k_vec = '1;
            end
            OP_SET: begin
              j_vec = '1;
            end
            OP_TOGGLE: begin
              j_vec = data_q;
              k_vec = data_q;
            end
            OP_NOP: begin
              j_vec = '0;
            end
            default: begin
              err_d = (op_q == OP_ILLEGAL);
            end
          endcase
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // JK register bank
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < WIDTH; b++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j_i (j_vec[b]),
      .k_i (k_vec[b]),
      .q_o (bank_q[b])
    );
  end

  assign q_o         = bank_q;
  assign busy_o      = (state_q == ST_EXEC);
  assign cmd_ready_o = (state_q == ST_IDLE) && !rst;
  assign done_o      = done_q;
  assign wrap_o      = wrap_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire
